// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: pedestrian/emergency requests in, lamps/walk/pending/phase out.
//   master: drives ped_req_ns, ped_req_ew, emerg_req, emerg_dir; reads the rest.
//   slave : the controller side (traffic_phase_ctrl).
interface traffic_phase_ctrl_if;
  logic ped_req_ns, ped_req_ew, emerg_req, emerg_dir;
  logic [2:0] sig_ns, sig_ew, phase;
  logic walk_ns, walk_ew, ped_pend_ns, ped_pend_ew;
  modport master(
    output ped_req_ns, ped_req_ew, emerg_req, emerg_dir,
    input sig_ns, sig_ew, walk_ns, walk_ew, ped_pend_ns, ped_pend_ew, phase
  );
  modport slave(
    input ped_req_ns, ped_req_ew, emerg_req, emerg_dir,
    output sig_ns, sig_ew, walk_ns, walk_ew, ped_pend_ns, ped_pend_ew, phase
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: parametrised NS/EW phase controller with all-red clearance and sticky pedestrian requests.
//   clk, rst (async, active-high); bus (slave): requests in, one-hot lamps 100/010/001, walk, pending, phase out.
//   Optional emergency preemption compiled in with EMERG_PREEMPT_EN.
module traffic_phase_ctrl #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 5,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic rst,
  traffic_phase_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;
  localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_CYC - 1);
  // Walk never outlasts the green, so its last cycle index always fits in cnt.
  localparam int WALK_EFF = WALK_CYC < GREEN_CYC ? WALK_CYC : GREEN_CYC;
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_EFF - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dur_m1;
  logic ped_pend_ns_q, ped_pend_ns_d, ped_pend_ew_q, ped_pend_ew_d;
  logic served_ns_q, served_ns_d, served_ew_q, served_ew_d;
  logic pre_ns, pre_ew, ent_ns, ent_ew;
`ifdef EMERG_PREEMPT_EN
  assign pre_ns = bus.emerg_req & ~bus.emerg_dir;
  assign pre_ew = bus.emerg_req & bus.emerg_dir;
`else
  assign pre_ns = 1'b0;
  assign pre_ew = 1'b0;
  logic unused_emerg;
  assign unused_emerg = bus.emerg_req ^ bus.emerg_dir;
`endif
  always_comb begin
    dur_m1 = (state_q == NS_GREEN || state_q == EW_GREEN) ? GREEN_M1 :
             (state_q == NS_YELLOW || state_q == EW_YELLOW) ? YELLOW_M1 : ALLRED_M1;
    state_d = state_q;
    cnt_d = cnt_q + CNT_W'(1);
    if (state_q > EW_YELLOW) begin
      state_d = ALLRED_A;
      cnt_d = '0;
    end else if ((state_q == NS_GREEN && pre_ew) || (state_q == EW_GREEN && pre_ns)) begin
      // opposing green is cut straight into its own yellow
      state_d = state_t'(state_q + 3'd1);
      cnt_d = '0;
    end else if ((state_q == NS_GREEN && pre_ns) || (state_q == EW_GREEN && pre_ew)) begin
      cnt_d = cnt_q;
    end else if (cnt_q == dur_m1) begin
      state_d = state_q == EW_YELLOW ? ALLRED_A : state_t'(state_q + 3'd1);
      cnt_d = '0;
    end
    ent_ns = state_q != NS_GREEN && state_d == NS_GREEN;
    ent_ew = state_q != EW_GREEN && state_d == EW_GREEN;
    served_ns_d = ent_ns ? ped_pend_ns_q : served_ns_q;
    served_ew_d = ent_ew ? ped_pend_ew_q : served_ew_q;
    // a request in the entry cycle re-arms pending for the following green
    ped_pend_ns_d = bus.ped_req_ns | (ped_pend_ns_q & ~ent_ns);
    ped_pend_ew_d = bus.ped_req_ew | (ped_pend_ew_q & ~ent_ew);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALLRED_A;
      cnt_q <= '0;
      ped_pend_ns_q <= 1'b0;
      ped_pend_ew_q <= 1'b0;
      served_ns_q <= 1'b0;
      served_ew_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ped_pend_ns_q <= ped_pend_ns_d;
      ped_pend_ew_q <= ped_pend_ew_d;
      served_ns_q <= served_ns_d;
      served_ew_q <= served_ew_d;
    end
  end
  assign bus.phase = state_q;
  assign bus.sig_ns = state_q == NS_GREEN ? 3'b001 : state_q == NS_YELLOW ? 3'b010 : 3'b100;
  assign bus.sig_ew = state_q == EW_GREEN ? 3'b001 : state_q == EW_YELLOW ? 3'b010 : 3'b100;
  assign bus.walk_ns = served_ns_q & (state_q == NS_GREEN) & (cnt_q <= WALK_M1) & ~(pre_ns | pre_ew);
  assign bus.walk_ew = served_ew_q & (state_q == EW_GREEN) & (cnt_q <= WALK_M1) & ~(pre_ns | pre_ew);
  assign bus.ped_pend_ns = ped_pend_ns_q;
  assign bus.ped_pend_ew = ped_pend_ew_q;
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised two-approach intersection controller, the successor to the fixed-timing NS/EW traffic controller. Every phase duration is a parameter, and each direction gets an all-red clearance interval. Pedestrian requests are latched sticky and served with a bounded walk window. An optional emergency-preemption mode can be compiled in. The block sits directly behind the board clock and drives the lamp and walk-signal registers.

## Interface
Parameters:
- GREEN_CYC, default 8: green duration per direction, in cycles (≥1).
- YELLOW_CYC, default 3: yellow duration, in cycles (≥1).
- ALLRED_CYC, default 2: all-red clearance before each green, in cycles (≥1).
- WALK_CYC, default 5: walk window at the start of a served green, in cycles (≥1).
- CNT_W, default 8: phase counter width; must hold max(durations)−1.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ped_req_ns  in  1  NS pedestrian button; level or pulse.
- ped_req_ew  in  1  EW pedestrian button.
- emerg_req  in  1  emergency preemption request; ignored unless EMERG_PREEMPT_EN is defined.
- emerg_dir  in  1  preemption direction: 0 = NS, 1 = EW.
- sig_ns  out  3  NS lamp, one-hot: 100 red, 010 yellow, 001 green.
- sig_ew  out  3  EW lamp, same encoding as sig_ns.
- walk_ns  out  1  NS pedestrian walk.
- walk_ew  out  1  EW pedestrian walk.
- ped_pend_ns  out  1  NS request latched, not yet served.
- ped_pend_ew  out  1  EW request latched, not yet served.
- phase  out  3  current state encoding (see Operation).

## Operation
- States, with their `phase` encoding, in this order: ALLRED_A=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_B=3, EW_GREEN=4, EW_YELLOW=5. EW_YELLOW returns to ALLRED_A.
- Illegal encodings 6 and 7 go to ALLRED_A with cnt=0 on the next edge.
- Up-counter `cnt`:
  - Cleared on every state entry and incremented each cycle.
  - The state exits when cnt == DUR−1, so each state lasts exactly DUR cycles.
  - No wrap occurs within a legal state.
- Lamps are a Moore decode of the state register:
  - ALLRED_A and ALLRED_B: both directions 100.
  - NS_GREEN: NS=001, EW=100. NS_YELLOW: NS=010, EW=100.
  - EW_GREEN: EW=001, NS=100. EW_YELLOW: EW=010, NS=100.
  - The two directions are never green or yellow simultaneously.
- Pedestrian handling (shown for NS; EW is symmetric with EW_GREEN):
  - ped_pend_ns is set on any cycle where ped_req_ns=1.
  - On the edge entering NS_GREEN, a set pending bit is copied to `served_ns` and cleared.
  - A request arriving in that same cycle still sets pending, so set wins over clear.
  - walk_ns = served_ns AND state==NS_GREEN AND cnt < WALK_CYC, i.e. min(WALK_CYC, GREEN_CYC) cycles.
  - A request arriving during NS_GREEN is not served in that green; it stays pending for the next NS green.

## Timing
- Reset (async assert): state=ALLRED_A, cnt=0, sig_ns=sig_ew=100, walk_*=0, ped_pend_*=0, served_*=0, phase=0. All outputs change without waiting for clk.
- After release: the first state edge occurs on the first clk rising edge with rst=0.
- Default full cycle: 2+8+3+2+8+3 = 26 cycles.
- Request-to-pending latency: 1 cycle (registered).
- Walk response: walk asserts in the first cycle of the served green.
- Reset mid-phase: the cycle restarts from ALLRED_A and all latched requests are lost.

## Configuration
- EMERG_PREEMPT_EN defined, with emerg_req=1:
  - Opposing green is cut: on the next edge, go to that direction's yellow with cnt=0.
  - Yellow and all-red always run to completion and are never cut.
  - In the requested direction's green, cnt freezes while emerg_req=1 and resumes counting on release.
  - walk_* is forced 0 while preempted; served_* is kept.
  - ped_pend_* continues to latch.
- EMERG_PREEMPT_EN undefined: emerg_req and emerg_dir are ignored, and behaviour is pure fixed-time plus pedestrian.

## Test plan
- Reset released with no requests, default parameters -> phase sequence 0,1,2,3,4,5 with dwell times 2,8,3,2,8,3; period 26; lamps one-hot as specified; walk_* stays 0.
- ped_req_ew 1-cycle pulse at EW_GREEN cnt=3 -> ped_pend_ew=1 next cycle; no walk in that green; walk_ew=1 for cycles 0–4 of the next EW_GREEN; pending clears on entry.
- ped_req_ns held high across the NS_GREEN entry edge -> walk_ns for 5 cycles and ped_pend_ns remains 1 (set wins over clear).
- rst asserted asynchronously mid NS_GREEN (cnt=4) -> sig_ns=100 and phase=0 before the next edge; the sequence restarts with a 2-cycle all-red.
- EMERG_PREEMPT_EN defined; emerg_req=1, emerg_dir=1 at NS_GREEN cnt=2, held for 20 cycles -> NS_YELLOW for 3 cycles, ALLRED_B for 2, then EW_GREEN held until release, then 8 more cycles of EW_GREEN.
- GREEN_CYC=1, WALK_CYC=5, ped_req_ns pending -> NS_GREEN lasts 1 cycle; walk_ns high for exactly 1 cycle.
